// File: rtl/morse_ctrl_pkg.sv
// Shared definitions for the Morse key controller: FSM encoding, symbol
// field widths and default timing constants.
package morse_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPress = 2'd1,
    StGap   = 2'd2,
    StHold  = 2'd3
  } state_t;

  localparam int unsigned LEN_W   = 3;
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned SYM_W   = LEN_W + CODE_W;
  localparam int unsigned CNT_W   = 26;
  localparam int unsigned MAX_LEN = 5;

  localparam int unsigned DEB_CYC_DEF = 500000;
  localparam int unsigned DOT_MAX_DEF = 12500000;
  localparam int unsigned GAP_CYC_DEF = 37500000;

endpackage

// File: rtl/antirrebote.sv
// Key debouncer: the output follows the input once the input has held a
// different level for DEB_CYC consecutive cycles.
module antirrebote
  import morse_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  localparam int unsigned CW = $clog2(DEB_CYC + 1);

  logic [CW-1:0] cnt_q;

  // Any return of in to the current output level restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      out   <= 1'b0;
    end else if (in == out) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEB_CYC - 1)) begin
      cnt_q <= '0;
      out   <= in;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/morse_ctrl.sv
// Morse key controller: classifies key presses into dots/dashes, assembles
// two symbols plus operation switches into a word and holds it until ack.
module morse_ctrl
  import morse_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF,
  parameter int unsigned DOT_MAX = DOT_MAX_DEF,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  input  logic [2:0] op,
  input  logic       ack,
  output logic [7:0] e0,
  output logic [7:0] e1,
  output logic [7:0] e2,
  output logic       valid,
  output logic       err,
  output logic [1:0] state
);

  state_t              state_q;
  logic [1:0]          sync_q;
  logic                key_db;
  logic                key_db_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [LEN_W-1:0]    len_q;
  logic [CODE_W-1:0]   code_q;
  logic [SYM_W-1:0]    slot0_q;
  logic                slot_q;
  logic                rise;
  logic                fall;
  logic                dash;

  antirrebote #(
    .DEB_CYC(DEB_CYC)
  ) u_deb (
    .clk  (clk),
    .reset(reset),
    .in   (sync_q[1]),
    .out  (key_db)
  );

  assign rise  = key_db & ~key_db_q;
  assign fall  = ~key_db & key_db_q;
  assign dash  = (cnt_q >= CNT_W'(DOT_MAX));
  assign state = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      sync_q   <= '0;
      key_db_q <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
      code_q   <= '0;
      slot0_q  <= '0;
      slot_q   <= 1'b0;
      e0       <= '0;
      e1       <= '0;
      e2       <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key};
      key_db_q <= key_db;
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            state_q <= StPress;
            cnt_q   <= '0;
          end
        end
        StPress: begin
          if (fall) begin
            state_q <= StGap;
            cnt_q   <= '0;
            if (len_q < LEN_W'(MAX_LEN)) begin
              code_q <= {code_q[CODE_W-2:0], dash};
              len_q  <= len_q + 1'b1;
            end else begin
              err <= 1'b1;
            end
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StGap: begin
          // A new press beats gap expiry in the same cycle.
          if (rise) begin
            state_q <= StPress;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
            cnt_q <= '0;
            if (!slot_q) begin
              slot0_q <= {len_q, code_q};
              slot_q  <= 1'b1;
              len_q   <= '0;
              code_q  <= '0;
              state_q <= StIdle;
            end else begin
              e0      <= slot0_q;
              e1      <= {len_q, code_q};
              e2      <= {5'b00000, op};
              valid   <= 1'b1;
              state_q <= StHold;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHold: begin
          if (ack) begin
            valid   <= 1'b0;
            err     <= 1'b0;
            slot_q  <= 1'b0;
            code_q  <= '0;
            len_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_ctrl.sv
// Directed bench for morse_ctrl with short timing; expected words are queued
// when a word is keyed and compared when valid rises.
module tb_morse_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key = 1'b0;
  logic [2:0] op = 3'b000;
  logic       ack = 1'b0;
  logic [7:0] e0, e1, e2;
  logic       valid, err;
  logic [1:0] state;

  typedef struct packed {
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       err;
  } word_t;

  word_t sb[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;

  morse_ctrl #(
    .DEB_CYC(4),
    .DOT_MAX(20),
    .GAP_CYC(60)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .key  (key),
    .op   (op),
    .ack  (ack),
    .e0   (e0),
    .e1   (e1),
    .e2   (e2),
    .valid(valid),
    .err  (err),
    .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic press(input int n);
    key = 1'b1;
    repeat (n) @(negedge clk);
    key = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic wait_word(input string tag);
    word_t exp;
    int    cyc = 0;
    while (valid !== 1'b1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_valid"}, 32'(valid), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      exp = sb.pop_front();
      check({tag, "_e0"}, 32'(e0), 32'(exp.e0));
      check({tag, "_e1"}, 32'(e1), 32'(exp.e1));
      check({tag, "_e2"}, 32'(e2), 32'(exp.e2));
      check({tag, "_err"}, 32'(err), 32'(exp.err));
      check({tag, "_state"}, 32'(state), 32'd3);
    end
  endtask

  initial begin
    // Reset state
    idle(2);
    check("rst_e0", 32'(e0), 32'd0);
    check("rst_e1", 32'(e1), 32'd0);
    check("rst_e2", 32'(e2), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    reset = 1'b1;
    idle(3);

    // Glitches shorter than the debounce window
    for (int i = 0; i < 4; i++) begin
      press(2);
      idle(6);
      check("glitch_state", 32'(state), 32'd0);
    end
    check("glitch_valid", 32'(valid), 32'd0);

    // Word: dot | dash dot, op=101
    op = 3'b101;
    sb.push_back('{e0: 8'h20, e1: 8'h42, e2: 8'h05, err: 1'b0});
    press(10); idle(80);
    press(30); idle(10); press(10); idle(80);
    wait_word("word");

    // Key activity during HOLD is ignored
    op = 3'b000;
    press(30); idle(80);
    check("hold_e0", 32'(e0), 32'h20);
    check("hold_e1", 32'(e1), 32'h42);
    check("hold_e2", 32'(e2), 32'h05);
    check("hold_state", 32'(state), 32'd3);
    pulse_ack();
    check("ack_valid", 32'(valid), 32'd0);
    check("ack_state", 32'(state), 32'd0);
    pulse_ack();
    check("idle_ack_state", 32'(state), 32'd0);
    check("idle_ack_valid", 32'(valid), 32'd0);
    check("idle_ack_e0", 32'(e0), 32'h20);

    // Overlong symbol: six dots, then one dot
    op = 3'b010;
    sb.push_back('{e0: 8'hA0, e1: 8'h20, e2: 8'h02, err: 1'b1});
    for (int i = 0; i < 6; i++) begin
      press(10); idle(10);
    end
    idle(70);
    check("over_err_sticky", 32'(err), 32'd1);
    press(10); idle(80);
    wait_word("over");
    pulse_ack();
    check("over_err_clr", 32'(err), 32'd0);
    check("over_valid_clr", 32'(valid), 32'd0);

    // Reset in GAP with slot 1 filled
    press(10); idle(80);
    press(10); idle(20);
    check("pre_rst_state", 32'(state), 32'd2);
    reset = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 32'd0);
    check("mid_rst_e0", 32'(e0), 32'd0);
    check("mid_rst_e1", 32'(e1), 32'd0);
    check("mid_rst_e2", 32'(e2), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    op = 3'b111;
    sb.push_back('{e0: 8'h21, e1: 8'h40, e2: 8'h07, err: 1'b0});
    press(30); idle(80);
    press(10); idle(10); press(10); idle(80);
    wait_word("post_rst");
    pulse_ack();

    // Press arrives exactly as the gap would expire
    op = 3'b000;
    sb.push_back('{e0: 8'h40, e1: 8'h21, e2: 8'h00, err: 1'b0});
    press(10); idle(60);
    key = 1'b1;
    idle(8);
    check("race_state", 32'(state), 32'd1);
    idle(2);
    key = 1'b0;
    idle(80);
    press(30); idle(80);
    wait_word("race");
    pulse_ack();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/morse_ctrl.md
MORSE_CTRL -- requirements
Module: morse_ctrl

Interface
REQ-001 Parameter DEB_CYC, default 500000, SHALL set the cycles the raw key must stay stable before the debounced level changes (10 ms at 50 MHz).
REQ-002 Parameter DOT_MAX, default 12500000, SHALL set the press length in cycles at or above which an element is a dash (250 ms).
REQ-003 Parameter GAP_CYC, default 37500000, SHALL set the released-key cycles that end a symbol (750 ms).
REQ-004 clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset (reset=0 resets).
REQ-006 key  in  1  raw, asynchronous Morse key; 1 = pressed.
REQ-007 op  in  3  operation switches, sampled at completion of a word.
REQ-008 ack  in  1  processor has consumed the port word; single-cycle pulse.
REQ-009 e0  out  8  first symbol {len[2:0], code[4:0]}.
REQ-010 e1  out  8  second symbol, same format.
REQ-011 e2  out  8  {5'b00000, op}.
REQ-012 valid  out  1  e0..e2 hold a complete, unconsumed word.
REQ-013 err  out  1  sticky: a symbol exceeded 5 elements since the last ack.
REQ-014 state  out  2  current FSM state, for the board displays.

Function
REQ-015 key SHALL pass a 2-flop synchronizer and then the debouncer; only the debounced level key_db SHALL drive the FSM.
REQ-016 FSM states SHALL be IDLE=0, PRESS=1, GAP=2, HOLD=3.
REQ-017 IDLE: on a key_db rising edge, go to PRESS and clear the cycle counter.
REQ-018 PRESS: increment the counter each cycle, saturating at all-ones; on a key_db falling edge, go to GAP, clear the counter, and record element bit = (counter >= DOT_MAX) (1 = dash, 0 = dot).
REQ-019 Recording an element with len<5: code <= {code[3:0], bit}, len <= len+1. With len==5: code and len unchanged, err <= 1.
REQ-020 GAP: a key_db rising edge SHALL return to PRESS with the counter cleared; counter == GAP_CYC-1 SHALL complete the symbol.
REQ-021 Symbol completion with slot=0: store {len,code} in internal slot0, set slot=1, clear code and len, go to IDLE.
REQ-022 Symbol completion with slot=1: load e0<=slot0, e1<={len,code}, e2<={5'b0,op} in the same cycle, set valid=1, go to HOLD.
REQ-023 e0..e2 SHALL change only at the HOLD-entry edge, so the processor never sees a partial word.
REQ-024 HOLD: key activity SHALL be ignored; on ack=1, in the next cycle valid=0, err=0, slot=0, code=0, len=0 and the state is IDLE.
REQ-025 ack outside HOLD SHALL have no effect.
REQ-026 A key_db edge and GAP expiry in the same cycle: the edge SHALL win (the symbol continues).
REQ-027 The debounced level SHALL update exactly DEB_CYC cycles after the synchronized raw level last changed.

Reset
REQ-028 While reset=0, all of the following SHALL be cleared asynchronously: state=IDLE, valid=0, err=0, e0=e1=e2=0, slot=0, code=0, len=0, counters=0, synchronizer and key_db=0.
REQ-029 Reset mid-operation SHALL discard any partial symbol or word; the first key press after release SHALL start a new word at slot 0.

Structure
REQ-030 A shared package SHALL hold the state encoding, the symbol field widths (LEN_W=3, CODE_W=5) and the default timing constants.
REQ-031 The debouncer SHALL be a separate sub-module named antirrebote, with parameter DEB_CYC, ports clk, reset, in, out.
REQ-032 Counter width SHALL be 26 bits, sufficient for the default GAP_CYC.

Verification (DEB_CYC=4, DOT_MAX=20, GAP_CYC=60)
REQ-033 Word test: press 10 cycles, release, wait 80 cycles, then press 30, release 10, press 10, release, wait 80; with op=3'b101 -> valid=1, e0=8'h20, e1=8'h42, e2=8'h05.
REQ-034 Overlong symbol: 6 dots in one symbol -> err=1 and that symbol's slot = 8'hA0; err clears one cycle after ack.
REQ-035 Glitch: 2-cycle key pulses -> key_db never changes, state stays IDLE.
REQ-036 Handshake: with valid=1, key presses -> e0..e2 unchanged; ack pulse -> valid=0 and state=IDLE in the next cycle; ack while in IDLE -> no change.
REQ-037 Reset mid-GAP: assert reset=0 with slot=1 -> all outputs 0; a following two-symbol entry produces a correct word.
REQ-038 Gap race: a key_db rising edge on the cycle the GAP counter reaches 59 -> no symbol completion, state=PRESS.
